// File: rtl/st_serial_sub4_pkg.sv
// st_serial_sub4_pkg: shared state encoding and counter width helper for the serial subtractor
package st_serial_sub4_pkg;
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
   function automatic int cnt_w(input int w);
      return $clog2(w);
   endfunction
endpackage

// File: rtl/st_serial_sub4_if.sv
// st_serial_sub4_if: start/busy/done operand and result bundle
//   master drives start, A, B, Bi and observes busy, done, D, Bo; slave is the subtractor side
interface st_serial_sub4_if #(parameter int W = 4);
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Bi;
   logic         busy;
   logic         done;
   logic [W-1:0] D;
   logic         Bo;
   modport master (output start, A, B, Bi, input busy, done, D, Bo);
   modport slave  (input start, A, B, Bi, output busy, done, D, Bo);
endinterface

// File: rtl/st_serial_sub4_fs.sv
// st_fs: combinational 1-bit full subtractor, D = A - B - Bi with borrow out Bo
//   inputs A, B, Bi; outputs D (difference bit), Bo (borrow out)
module st_fs (
   output logic Bo,
   output logic D,
   input  logic A,
   input  logic B,
   input  logic Bi
);
   logic x;
   assign x  = A ^ B;
   assign D  = x ^ Bi;
   assign Bo = (~A & B) | (~x & Bi);
endmodule

// File: rtl/st_serial_sub4.sv
// st_serial_sub4: bit-serial W-bit subtractor, D = A - B - Bi one bit per clock, LSB first
//   clk, rst (sync, active high); bus.slave carries start/A/B/Bi in and busy/done/D/Bo out
module st_serial_sub4
   import st_serial_sub4_pkg::*;
#(
   parameter int W = 4
) (
   input logic            clk,
   input logic            rst,
   st_serial_sub4_if.slave bus
);
   localparam int CW = cnt_w(W);
   state_t state, state_n;
   logic [W-1:0] sa, sb, d_q;
   // sr only holds the W-1 lower result bits; the final bit joins them on the last cycle
   logic [W-2:0] sr;
   logic [CW-1:0] cnt;
   logic br, bo_q, d, bout, accept, last;
   st_fs u_fs (
      .Bo (bout),
      .D  (d),
      .A  (sa[0]),
      .B  (sb[0]),
      .Bi (br)
   );
   assign accept   = bus.start && (state == IDLE || state == DONE);
   assign last     = state == SHIFT && cnt == CW'(W - 1);
   assign bus.busy = state == SHIFT;
   assign bus.done = state == DONE;
   assign bus.D    = d_q;
   assign bus.Bo   = bo_q;
   always_comb begin
      state_n = accept ? SHIFT : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         sr    <= '0;
         br    <= 1'b0;
         cnt   <= '0;
         d_q   <= '0;
         bo_q  <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            sa  <= bus.A;
            sb  <= bus.B;
            br  <= bus.Bi;
            cnt <= '0;
         end else if (state == SHIFT) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            sr  <= (W-1)'({d, sr} >> 1);
            br  <= bout;
            cnt <= cnt + 1'b1;
            if (last) begin
               d_q  <= {d, sr};
               bo_q <= bout;
            end
         end
      end
   end
endmodule

// File: tb/tb_st_serial_sub4.sv
// tb_st_serial_sub4: randomized self-checking bench for st_serial_sub4 at W=4 and W=8
module tb_st_serial_sub4;
   localparam int W = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int errs = 0;
   int checks = 0;
   st_serial_sub4_if #(.W(W)) bus ();
   st_serial_sub4_if #(.W(8)) bus8 ();
   st_serial_sub4 #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   st_serial_sub4 #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // reference: plain integer subtraction, wrapped to w bits; borrow is a negative raw result
   function automatic int ref_d(input int a, b, bi, w);
      return (a - b - bi) & ((1 << w) - 1);
   endfunction
   function automatic int ref_bo(input int a, b, bi);
      return (a < b + bi) ? 1 : 0;
   endfunction

   task automatic start_op(input int a, b, bi);
      @(negedge clk);
      bus.A = W'(a);
      bus.B = W'(b);
      bus.Bi = 1'(bi);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // waits for done, scrambling operands meanwhile; returns cycles waited and busy cycles seen
   task automatic wait_done(output int n, output int bc);
      n = 0;
      bc = 0;
      while (!bus.done && n < 50) begin
         bc += int'(bus.busy);
         bus.A = W'($urandom);
         bus.B = W'($urandom);
         bus.Bi = 1'($urandom);
         @(negedge clk);
         n++;
      end
   endtask

   task automatic check_res(input string tag, input int a, b, bi, lat);
      int n, bc;
      wait_done(n, bc);
      chk({tag, "_lat"}, n, lat);
      chk({tag, "_busy"}, bc, lat);
      chk({tag, "_done"}, int'(bus.done), 1);
      chk({tag, "_D"}, int'(bus.D), ref_d(a, b, bi, W));
      chk({tag, "_Bo"}, int'(bus.Bo), ref_bo(a, b, bi));
   endtask

   task automatic do_op(input string tag, input int a, b, bi);
      start_op(a, b, bi);
      check_res(tag, a, b, bi, W);
   endtask

   initial begin
      int a, b, bi, n, dn;
      bus.start = 1'b0;
      bus.A = '0;
      bus.B = '0;
      bus.Bi = 1'b0;
      bus8.start = 1'b0;
      bus8.A = '0;
      bus8.B = '0;
      bus8.Bi = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_D", int'(bus.D), 0);
      chk("rst_Bo", int'(bus.Bo), 0);

      do_op("9m3", 9, 3, 0);
      @(negedge clk);
      chk("pulse_len", int'(bus.done), 0);
      repeat (3) @(negedge clk);
      chk("hold_D", int'(bus.D), 6);
      chk("hold_busy", int'(bus.busy), 0);

      do_op("3m9", 3, 9, 0);
      do_op("0m0b", 0, 0, 1);
      do_op("fmfb", 15, 15, 1);
      do_op("fm0", 15, 0, 0);

      // a start pulsed mid-SHIFT must not restart or alter the operation
      start_op(8, 1, 0);
      bus.start = 1'b1;
      bus.A = W'(1);
      bus.B = W'(1);
      @(negedge clk);
      bus.start = 1'b0;
      check_res("midstart", 8, 1, 0, W - 1);
      @(negedge clk);
      chk("midstart_idle", int'(bus.busy), 0);

      // back-to-back: new start accepted in the done cycle
      start_op(5, 2, 0);
      check_res("b2b1", 5, 2, 0, W);
      bus.A = W'(2);
      bus.B = W'(5);
      bus.Bi = 1'b0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("b2b_busy", int'(bus.busy), 1);
      chk("b2b_hold_D", int'(bus.D), 3);
      check_res("b2b2", 2, 5, 0, W);

      // reset during SHIFT abandons the operation
      do_op("pre_rst", 9, 3, 0);
      start_op(12, 4, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_busy", int'(bus.busy), 0);
      chk("mid_rst_done", int'(bus.done), 0);
      chk("mid_rst_D", int'(bus.D), 0);
      chk("mid_rst_Bo", int'(bus.Bo), 0);
      dn = 0;
      repeat (W + 3) begin
         @(negedge clk);
         dn += int'(bus.done);
      end
      chk("mid_rst_nodone", dn, 0);

      repeat (200) begin
         a = int'($urandom_range(0, 15));
         b = int'($urandom_range(0, 15));
         bi = int'($urandom_range(0, 1));
         do_op("rnd4", a, b, bi);
      end

      repeat (200) begin
         a = int'($urandom_range(0, 255));
         b = int'($urandom_range(0, 255));
         bi = int'($urandom_range(0, 1));
         @(negedge clk);
         bus8.A = 8'(a);
         bus8.B = 8'(b);
         bus8.Bi = 1'(bi);
         bus8.start = 1'b1;
         @(negedge clk);
         bus8.start = 1'b0;
         n = 0;
         while (!bus8.done && n < 50) begin
            bus8.A = 8'($urandom);
            bus8.B = 8'($urandom);
            @(negedge clk);
            n++;
         end
         chk("rnd8_lat", n, 8);
         chk("rnd8_D", int'(bus8.D), ref_d(a, b, bi, 8));
         chk("rnd8_Bo", int'(bus8.Bo), ref_bo(a, b, bi));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
